// File: rtl/stall_pkg.sv
// Shared FSM encoding and default widths for the stall-buffer reader.
package stall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/slot_reader.sv
// Pulls items from the head of a two-slot stall buffer and holds one item
// for a valid/ready consumer, counting completed handshakes.
module slot_reader
  import stall_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              buf_empty,
  input  logic              buf_full,
  input  logic              buf_enq,
  output logic              buf_deq,
  input  logic              stall_req,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  accept_cnt
);

  state_t state;
  logic   want;

  // The buffer's writer wins a same-cycle conflict; the dequeue retries next cycle.
  assign want = !reset && !buf_empty && !stall_req && !flush &&
                (state == IDLE || (state == VALID && out_ready));
  assign buf_deq = want && !(buf_enq && !buf_full);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      accept_cnt <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready)
        accept_cnt <= accept_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (buf_deq) begin
            state     <= VALID;
            out_valid <= 1'b1;
            out_data  <= buf_data;
          end
        end
        VALID: begin
          if (out_ready) begin
            if (buf_deq) begin
              out_data <= buf_data;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end else if (stall_req) begin
            state     <= STALL;
            out_valid <= 1'b0;
          end
        end
        STALL: begin
          if (!stall_req) begin
            state     <= VALID;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_reader.sv
// Directed bench for slot_reader: a two-slot buffer model feeds the DUT and a
// scoreboard checks every handshaked item in order.
module tb_slot_reader;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [DATA_W-1:0] buf_data;
  logic              buf_empty;
  logic              buf_full;
  logic              buf_enq;
  logic              buf_deq;
  logic              stall_req;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  accept_cnt;

  logic [DATA_W-1:0] enq_data;
  logic [DATA_W-1:0] slot0, slot1;
  int                fill;

  int n_vec = 0;
  int n_miss = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  slot_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .buf_data   (buf_data),
    .buf_empty  (buf_empty),
    .buf_full   (buf_full),
    .buf_enq    (buf_enq),
    .buf_deq    (buf_deq),
    .stall_req  (stall_req),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  // Two-slot buffer model: enqueue dropped when full, head at slot0.
  assign buf_data  = slot0;
  assign buf_empty = (fill == 0);
  assign buf_full  = (fill == 2);

  initial begin
    slot0 = '0;
    slot1 = '0;
    fill  = 0;
  end

  always @(posedge clk) begin
    if (buf_enq && !buf_full) begin
      if (fill == 0) slot0 <= enq_data;
      else           slot1 <= enq_data;
      fill <= fill + 1;
    end else if (buf_deq) begin
      slot0 <= slot1;
      fill  <= fill - 1;
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every counted handshake must match the next expected item.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_deq(input string name, input logic exp);
    #1;
    check(name, {31'd0, buf_deq}, {31'd0, exp});
  endtask

  task automatic enq(input logic [DATA_W-1:0] d);
    buf_enq  = 1'b1;
    enq_data = d;
    step();
    buf_enq  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; buf_enq = 1'b0; enq_data = '0;
    stall_req = 1'b0; out_ready = 1'b0;
    step(); step();

    // Reset state, with an item already waiting in the buffer.
    enq(32'hA5A5_0001);
    check_deq("rst_deq", 1'b0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_cnt", 32'(accept_cnt), 32'd0);

    // First item: deq cycle 1, valid cycle 2, counted cycle 3.
    out_ready = 1'b1;
    reset = 1'b0;
    check_deq("first_deq", 1'b1);
    exp_q.push_back(32'hA5A5_0001);
    step();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_data", out_data, 32'hA5A5_0001);
    step();
    check("first_cnt", 32'(accept_cnt), 32'd1);
    check("first_idle", {31'd0, out_valid}, 32'd0);

    // Full buffer drained back to back.
    out_ready = 1'b0;
    enq(32'h11);
    enq(32'h22);
    check("full_flag", {31'd0, buf_full}, 32'd1);
    out_ready = 1'b1;
    check_deq("b2b_deq0", 1'b1);
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    step();
    check("b2b_d0", out_data, 32'h11);
    check_deq("b2b_deq1", 1'b1);
    step();
    check("b2b_d1", out_data, 32'h22);
    check("b2b_v1", {31'd0, out_valid}, 32'd1);
    step();
    check("b2b_cnt", 32'(accept_cnt), 32'd3);

    // Enqueue priority while IDLE with a non-empty buffer.
    out_ready = 1'b0;
    enq(32'h55);
    buf_enq = 1'b1; enq_data = 32'h56;
    check_deq("enq_prio", 1'b0);
    step();
    buf_enq = 1'b0;
    check_deq("enq_retry", 1'b1);
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h56);
    step();
    out_ready = 1'b1;
    step(); step(); step();
    check("enq_cnt", 32'(accept_cnt), 32'd5);

    // Stall while VALID and not ready: item retained, valid masked.
    out_ready = 1'b0;
    enq(32'h33);
    step();
    check("stall_pre", out_data, 32'h33);
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'd0, out_valid}, 32'd0);
      check("stall_data", out_data, 32'h33);
    end
    stall_req = 1'b0;
    step();
    check("stall_exit", {31'd0, out_valid}, 32'd1);
    check("stall_exit_d", out_data, 32'h33);
    exp_q.push_back(32'h33);
    out_ready = 1'b1;
    step();
    check("stall_cnt", 32'(accept_cnt), 32'd6);

    // Flush during a handshake: dropped, not counted.
    out_ready = 1'b0;
    enq(32'h44);
    step();
    out_ready = 1'b1;
    flush = 1'b1;
    check_deq("flush_deq", 1'b0);
    step();
    flush = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_data", out_data, 32'd0);
    check("flush_cnt", 32'(accept_cnt), 32'd6);

    // Stall and ready together: handshake counts, no dequeue that cycle.
    out_ready = 1'b0;
    enq(32'h77);
    enq(32'h78);
    step();
    check("sr_pre", out_data, 32'h77);
    stall_req = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'h77);
    check_deq("sr_deq", 1'b0);
    step();
    check("sr_idle", {31'd0, out_valid}, 32'd0);
    check("sr_cnt", 32'(accept_cnt), 32'd7);
    stall_req = 1'b0;
    exp_q.push_back(32'h78);
    step(); step();
    check("sr_cnt2", 32'(accept_cnt), 32'd8);

    // Reset mid-handshake discards the held item.
    out_ready = 1'b0;
    enq(32'h99);
    step();
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_cnt", 32'(accept_cnt), 32'd0);

    // 17 handshakes wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      enq(32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
      step(); step();
    end
    check("wrap_cnt", 32'(accept_cnt), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/slot_reader.md
SLOT_READER -- requirements
Module: slot_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of buffer and output data.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-item counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  pipeline flush; discards held item.
REQ-006 buf_data  input  DATA_W  head slot of the two-slot stall buffer (combinational).
REQ-007 buf_empty  input  1  buffer holds zero items.
REQ-008 buf_full  input  1  buffer holds two items.
REQ-009 buf_enq  input  1  writer's enqueue strobe into the same buffer this cycle.
REQ-010 buf_deq  output  1  dequeue strobe to buffer.
REQ-011 stall_req  input  1  hazard stall from downstream control.
REQ-012 out_data  output  DATA_W  held item presented downstream.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 accept_cnt  output  CNT_W  count of completed out_valid&&out_ready handshakes.

Function
REQ-016 SHALL implement FSM states IDLE (no held item), VALID (item held, out_valid=1), STALL (item held, out_valid=0).
REQ-017 buf_deq SHALL be combinational: want = !buf_empty && !stall_req && !flush && (state==IDLE || (state==VALID && out_ready)); buf_deq = want && !(buf_enq && !buf_full).
REQ-018 Enqueue has priority in the buffer: buf_deq SHALL be suppressed whenever buf_enq && !buf_full, retried next cycle.
REQ-019 On buf_deq, out_data SHALL load buf_data at the same edge; next state VALID (1-cycle latency buffer head -> out_valid).
REQ-020 VALID with out_ready and no buf_deq SHALL go to IDLE, out_valid low next cycle.
REQ-021 VALID with out_ready and buf_deq SHALL stay VALID with new data (back-to-back, one item per cycle sustained).
REQ-022 VALID with stall_req and !out_ready SHALL go to STALL, retaining out_data.
REQ-023 VALID with stall_req and out_ready in same cycle: handshake completes (counted), next state IDLE, no deq.
REQ-024 STALL SHALL return to VALID on first cycle stall_req=0; out_data unchanged.
REQ-025 IDLE with stall_req SHALL stay IDLE, buf_deq=0.
REQ-026 out_valid SHALL be 1 only in VALID; out_data stable while VALID and !out_ready.
REQ-027 accept_cnt SHALL increment by 1 per handshake (out_valid && out_ready), wrapping modulo 2^CNT_W.
REQ-028 flush SHALL force next state IDLE, out_data to 0, buf_deq=0 that cycle; a handshake in the flush cycle SHALL NOT be counted; accept_cnt otherwise retained.
REQ-029 flush SHALL take priority over stall_req, out_ready and buf_deq logic.

Reset
REQ-030 On reset: state IDLE, out_valid 0, out_data 0, accept_cnt 0, buf_deq 0; reset overrides flush.
REQ-031 Reset mid-handshake SHALL discard held item without counting it.

Structure
REQ-032 FSM state encoding (IDLE/VALID/STALL) and default widths SHALL live in shared package stall_pkg.
REQ-033 Single module, no sub-modules; accept counter inline.

Verification
REQ-034 Reset, buffer holds 0xA5A5_0001, out_ready=1 -> buf_deq cycle 1, out_valid with 0xA5A50001 cycle 2, accept_cnt=1 cycle 3.
REQ-035 Buffer full {0x11,0x22}, out_ready=1 constant -> deq two consecutive cycles, out_data 0x11 then 0x22, out_valid high 2 cycles, accept_cnt=2.
REQ-036 buf_enq=1, buf_full=0, buffer non-empty, state IDLE -> buf_deq=0 that cycle, deq occurs next cycle after buf_enq drops.
REQ-037 VALID 0x33, out_ready=0, stall_req 3 cycles -> STALL, out_valid 0 for 3 cycles, out_data 0x33 kept; stall drop -> out_valid=1 0x33.
REQ-038 VALID 0x44 with out_ready=1 and flush=1 same cycle -> next IDLE, out_data 0, accept_cnt unchanged.
REQ-039 CNT_W=4, 17 handshakes from reset -> accept_cnt = 1 after wrap.
